// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, owner codes, starve width.
// No logic; types and constants only.
// No flow control.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of fetch arbitration losses; force_if once the limit is reached.
// force_if follows the registered count combinationally.
// No flow control; clr has priority over inc.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_if
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign force_if = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data; one transaction in flight.
// Request to rvalid is MEM_LAT+2 cycles; a new transaction every MEM_LAT+3 cycles.
// Requesters hold req until rvalid; the loser stalls via stall_if/stall_mem.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be 1 or more");
  end
  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, we_q;
  logic             force_if;
  logic             take, fetch_wins, last_wait;
  logic             starve_inc, starve_clr;
  logic             en_d, we_d, ifg_d, dg_d, ifrv_d, drv_d, cap_if, cap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req || d_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    take       = (state_q == IDLE) && (if_req || d_req);
    // data wins unless fetch has lost STARVE_MAX times in a row
    fetch_wins = if_req && (!d_req || force_if);
    starve_inc = (state_q == IDLE) && if_req && !fetch_wins;
    starve_clr = (state_q == IDLE) && (!if_req || fetch_wins);
    last_wait  = (state_q == WAIT) && (cnt_q == CNT_W'(1));

    en_d   = take;
    we_d   = take && !fetch_wins && d_we;
    ifg_d  = take && fetch_wins;
    dg_d   = take && !fetch_wins;
    ifrv_d = last_wait && (owner_q == OWN_IF);
    drv_d  = last_wait && (owner_q == OWN_D);
    cap_if = ifrv_d && !we_q;
    cap_d  = drv_d && !we_q;

    cnt_d = cnt_q;
    case (state_q)
      ISSUE:   cnt_d = LAT_INIT;
      WAIT:    cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // mem_addr/mem_wdata double as the latched copies of the winning request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mem_en    <= en_d;
      mem_we    <= we_d;
      if_gnt    <= ifg_d;
      d_gnt     <= dg_d;
      if_rvalid <= ifrv_d;
      d_rvalid  <= drv_d;
      if (take) begin
        owner_q   <= fetch_wins ? OWN_IF : OWN_D;
        we_q      <= !fetch_wins && d_we;
        mem_addr  <= fetch_wins ? if_addr : d_addr;
        mem_wdata <= fetch_wins ? '0 : d_wdata;
      end
      if (cap_if) if_rdata <= mem_rdata;
      if (cap_d)  d_rdata  <= mem_rdata;
    end
  end

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .force_if(force_if)
  );

  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = d_req & ~d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int L    = 2;
  localparam int SMAX = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        if_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] if_addr1 = '0, d_addr1 = '0, d_wdata1 = '0, mem_rdata1 = '0;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, stall_if1, stall_mem1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // environment memory
  logic [31:0] mem [logic [31:0]];
  int          rd_due = -1;
  logic [31:0] rd_addr = '0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // model: a transaction decided at idle cycle t is granted at t+1, answered at t+2+L
  int          cyc = 0, next_idle = 0, starve = 0;
  int          gnt_cyc = -1, rv_cyc = -1;
  logic        gnt_own = 1'b0, gnt_we = 1'b0, rv_own = 1'b0, rv_we = 1'b0;
  logic [31:0] gnt_addr = '0, gnt_wdata = '0, pend = '0;
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
  logic        exp_ifr = 1'b0, exp_dr = 1'b0, prev_ifr = 1'b0, prev_dr = 1'b0;
  logic        in_rst = 1'b1, random_mode = 1'b0;

  // requesters
  logic [31:0] if_q[$];
  txn_t        d_q[$];
  logic        if_act = 1'b0, d_act = 1'b0;
  logic [31:0] if_cur = '0;
  txn_t        d_cur = '0;

  // event logs for directed expectations
  int          if_gnt_cycs[$];
  logic [15:0] order = '0;
  int          n_gnt = 0, n_if_gnt = 0, d_rv_cnt = 0, stall_mem_cnt = 0;
  int          last_d_gnt_cyc = -1, last_d_rv_cyc = -1;
  logic        seen_we = 1'b0;
  logic [31:0] seen_addr = '0, seen_wdata = '0, last_d_rdata = '0;

  task automatic model_reset();
    next_idle = 0; starve = 0; gnt_cyc = -1; rv_cyc = -1; rd_due = -1;
    exp_if_rdata = '0; exp_d_rdata = '0; prev_ifr = 1'b0; prev_dr = 1'b0;
    if_act = 1'b0; d_act = 1'b0; if_q.delete(); d_q.delete();
  endtask

  task automatic step();
    logic exp_en, fetch;
    @(posedge clk); #1; cyc++;
    if (in_rst) begin
      chk("rst_ctrl", 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}), 64'd0);
      chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
      chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
      exp_ifr = 1'b0; exp_dr = 1'b0;
    end else begin
      exp_en  = (cyc == gnt_cyc);
      exp_ifr = (cyc == rv_cyc) && !rv_own;
      exp_dr  = (cyc == rv_cyc) && rv_own;
      if ((cyc == rv_cyc) && !rv_we) begin
        if (rv_own) exp_d_rdata = pend;
        else        exp_if_rdata = pend;
      end
      chk("if_gnt", 64'(if_gnt), 64'(exp_en && !gnt_own));
      chk("d_gnt", 64'(d_gnt), 64'(exp_en && gnt_own));
      chk("mem_en", 64'(mem_en), 64'(exp_en));
      chk("if_rvalid", 64'(if_rvalid), 64'(exp_ifr));
      chk("d_rvalid", 64'(d_rvalid), 64'(exp_dr));
      chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
      chk("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
      if (exp_en) begin
        chk("mem_we", 64'(mem_we), 64'(gnt_we));
        chk("mem_addr", 64'(mem_addr), 64'(gnt_addr));
        if (gnt_we) chk("mem_wdata", 64'(mem_wdata), 64'(gnt_wdata));
      end
    end
    if (if_gnt) begin if_gnt_cycs.push_back(cyc); order = {order[14:0], 1'b0}; n_gnt++; n_if_gnt++; end
    if (d_gnt) begin
      order = {order[14:0], 1'b1}; n_gnt++; last_d_gnt_cyc = cyc;
      seen_we = mem_we; seen_addr = mem_addr; seen_wdata = mem_wdata;
    end
    if (d_rvalid) begin d_rv_cnt++; last_d_rv_cyc = cyc; last_d_rdata = d_rdata; end
    if (mem_en && rst_n) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin rd_due = cyc + L; rd_addr = mem_addr; end
    end
    mem_rdata = (cyc == rd_due) ? rd(rd_addr) : $urandom;
    if (prev_ifr) if_act = 1'b0;
    if (prev_dr)  d_act = 1'b0;
    if (random_mode && !if_act && if_q.size() == 0 && $urandom_range(0, 2) == 0)
      if_q.push_back(32'($urandom_range(0, 15)) << 2);
    if (random_mode && !d_act && d_q.size() == 0 && $urandom_range(0, 2) == 0)
      d_q.push_back('{we: 1'($urandom), addr: 32'($urandom_range(0, 15)) << 2, wdata: $urandom});
    if (!in_rst && !if_act && if_q.size() > 0) begin if_cur = if_q.pop_front(); if_act = 1'b1; end
    if (!in_rst && !d_act && d_q.size() > 0) begin d_cur = d_q.pop_front(); d_act = 1'b1; end
    if_req  = if_act;
    if_addr = if_act ? if_cur : $urandom;
    d_req   = d_act;
    d_we    = d_act ? d_cur.we : 1'($urandom);
    d_addr  = d_act ? d_cur.addr : $urandom;
    d_wdata = d_act ? d_cur.wdata : $urandom;
    prev_ifr = exp_ifr; prev_dr = exp_dr;
    #1;
    if (!in_rst) begin
      chk("stall_if", 64'(stall_if), 64'(if_req && !exp_ifr));
      chk("stall_mem", 64'(stall_mem), 64'(d_req && !exp_dr));
    end
    if (stall_mem) stall_mem_cnt++;
    if (!in_rst && cyc >= next_idle) begin
      fetch = if_req && (!d_req || starve == SMAX);
      if (if_req || d_req) begin
        gnt_cyc = cyc + 1; gnt_own = !fetch; gnt_we = !fetch && d_we;
        gnt_addr = fetch ? if_addr : d_addr; gnt_wdata = d_wdata;
        rv_cyc = cyc + 2 + L; rv_own = !fetch; rv_we = gnt_we;
        pend = rd(gnt_addr); next_idle = cyc + 3 + L;
      end
      if (if_req && !fetch) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else starve = 0;
    end
  endtask

  task automatic drain(input string name, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (!if_act && !d_act && if_q.size() == 0 && d_q.size() == 0 && cyc >= next_idle) break;
      step();
    end
    chk(name, 64'(!if_act && !d_act && cyc >= next_idle), 64'd1);
    step(); step();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int g1, r1;
    logic        e1;
    logic [31:0] a1, rd1;

    model_reset();
    step(); step(); step();
    rst_n = 1'b1; in_rst = 1'b0;
    step();

    // single lw
    mem[32'h40] = 32'hDEADBEEF;
    d_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    stall_mem_cnt = 0;
    step(); s = cyc;
    drain("lw_done", 30);
    chk("lw_gnt_lat", 64'(last_d_gnt_cyc - s), 64'd1);
    chk("lw_rv_lat", 64'(last_d_rv_cyc - s), 64'd4);
    chk("lw_rdata", 64'(last_d_rdata), 64'hDEADBEEF);
    chk("lw_stall_cycles", 64'(stall_mem_cnt), 64'd4);

    // single sw
    d_q.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'h1234});
    step(); s = cyc;
    drain("sw_done", 30);
    chk("sw_gnt_lat", 64'(last_d_gnt_cyc - s), 64'd1);
    chk("sw_mem_we", 64'(seen_we), 64'd1);
    chk("sw_mem_addr", 64'(seen_addr), 64'h80);
    chk("sw_mem_wdata", 64'(seen_wdata), 64'h1234);
    chk("sw_rv_lat", 64'(last_d_rv_cyc - s), 64'd4);
    chk("sw_rdata_kept", 64'(d_rdata), 64'hDEADBEEF);

    // contention: D,D,D,D,IF,D,D,D,D,IF
    order = '0; n_gnt = 0; n_if_gnt = 0;
    for (int i = 0; i < 8; i++) d_q.push_back('{we: 1'b0, addr: 32'(i) << 2, wdata: 32'h0});
    if_q.push_back(32'h1000); if_q.push_back(32'h1004);
    for (int i = 0; i < 120 && n_gnt < 10; i++) step();
    chk("cont_gnts", 64'(n_gnt), 64'd10);
    chk("cont_order", 64'(order[9:0]), 64'b1111011110);
    drain("cont_done", 40);
    chk("cont_if_gnts", 64'(n_if_gnt), 64'd2);

    // back-to-back fetch
    if_gnt_cycs.delete();
    for (int i = 0; i < 4; i++) if_q.push_back(32'h100 + 32'(4 * i));
    drain("b2b_done", 60);
    chk("b2b_count", 64'(if_gnt_cycs.size()), 64'd4);
    if (if_gnt_cycs.size() == 4)
      for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(if_gnt_cycs[i] - if_gnt_cycs[i-1]), 64'd5);

    // randomized traffic
    random_mode = 1'b1;
    for (int i = 0; i < 1500; i++) step();
    random_mode = 1'b0;
    drain("rand_done", 60);

    // reset in the middle of a lw
    d_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    step(); step(); step();
    rst_n = 1'b0; in_rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    model_reset();
    #1;
    chk("rst_now_ctrl", 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_mem}), 64'd0);
    chk("rst_now_data", {if_rdata, d_rdata}, 64'd0);
    chk("rst_now_mem", {mem_addr, mem_wdata}, 64'd0);
    step(); step();
    rst_n = 1'b1; in_rst = 1'b0;
    d_rv_cnt = 0;
    for (int i = 0; i < 8; i++) step();
    chk("rst_no_rvalid", 64'(d_rv_cnt), 64'd0);
    d_q.push_back('{we: 1'b0, addr: 32'h304, wdata: 32'h0});
    step(); s = cyc;
    drain("post_rst_done", 30);
    chk("post_rst_rv_lat", 64'(last_d_rv_cyc - s), 64'd4);
    chk("post_rst_rdata", 64'(last_d_rdata), 64'(rd(32'h304)));

    // MEM_LAT=1 instance: single fetch
    g1 = -10; r1 = -10; e1 = 1'b0; a1 = '0; rd1 = '0;
    if_req1 = 1'b1; if_addr1 = 32'h200; mem_rdata1 = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (if_gnt1) begin g1 = c; e1 = mem_en1; a1 = mem_addr1; end
      if (if_rvalid1) begin r1 = c; rd1 = if_rdata1; end
      mem_rdata1 = (c == 2) ? 32'hCAFEF00D : $urandom;
      if (c == r1 + 1) if_req1 = 1'b0;
    end
    chk("lat1_gnt_cycle", 64'(g1), 64'd1);
    chk("lat1_mem_en", 64'(e1), 64'd1);
    chk("lat1_mem_addr", 64'(a1), 64'h200);
    chk("lat1_rv_cycle", 64'(r1), 64'd3);
    chk("lat1_rdata", 64'(rd1), 64'hCAFEF00D);
    chk("lat1_req_dropped", 64'(if_req1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
